// File: rtl/obi_mem_responder_pkg.sv
// Shared types for the OBI responder: FSM state encoding and bus data width.
package obi_mem_responder_pkg;

    localparam int OBI_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } obi_rsp_state_t;

endpackage

// File: rtl/obi_mem_responder_pipe.sv
// STAGES-deep {valid, data} shift register with synchronous clear.
// Each stage's data only moves when its valid moves, so the output data holds between responses.
module obi_rsp_pipe #(
    parameter int STAGES = 1,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    logic [STAGES-1:0]             vld_p;
    logic [STAGES-1:0][DATA_W-1:0] data_p;

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_p  <= '0;
            data_p <= '0;
        end else begin
            vld_p[0] <= in_vld;
            if (in_vld) begin
                data_p[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1];
                if (vld_p[i-1]) begin
                    data_p[i] <= data_p[i-1];
                end
            end
        end
    end

    assign out_vld  = vld_p[STAGES-1];
    assign out_data = data_p[STAGES-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI-style memory responder: grant FSM with optional wait-states, outstanding limit,
// single-port word RAM, fixed-latency in-order response pipeline and sticky protocol checker.
module obi_mem_responder
    import obi_mem_responder_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter int    LATENCY   = 1,
    parameter int    GNT_WAIT  = 0,
    parameter int    MAX_OUT   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  proc_req,
    input  logic [31:0]           addr,
    input  logic [OBI_DATA_W-1:0] wdata,
    input  logic                  web,
    output logic                  rdy,
    output logic [OBI_DATA_W-1:0] rdata,
    output logic                  valid,
    output logic                  protocol_err
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int WAIT_W = (GNT_WAIT > 2) ? $clog2(GNT_WAIT) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    obi_rsp_state_t        state;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]      out_cnt;
    logic                  accept;
    logic [ADDR_W-1:0]     idx;
    logic [OBI_DATA_W-1:0] rsp_data;

    logic                  pend_q;
    logic [31:0]           addr_q;
    logic [OBI_DATA_W-1:0] wdata_q;
    logic                  web_q;
    logic                  viol;

    logic [OBI_DATA_W-1:0] mem [DEPTH];

    assign rdy    = (state == READY) && (out_cnt < MAX_CNT);
    assign accept = proc_req && rdy;
    assign idx    = addr[ADDR_W+1:2];

    // A request held while ungranted must keep its payload stable until the grant.
    assign viol = pend_q && (!proc_req || (addr != addr_q) || (web != web_q) || (wdata != wdata_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= (GNT_WAIT == 0) ? READY : IDLE;
            wait_cnt     <= '0;
            out_cnt      <= '0;
            pend_q       <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            // The IDLE cycle counts as the first wait-state, so WAIT covers GNT_WAIT-1 cycles.
            case (state)
                IDLE: begin
                    if (proc_req) begin
                        if (GNT_WAIT > 1) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_W'(GNT_WAIT - 2);
                        end else begin
                            state <= READY;
                        end
                    end
                end
                WAIT: begin
                    if (!proc_req) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= READY;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                READY: begin
                    if ((GNT_WAIT > 0) && (accept || !proc_req)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept && !valid) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end else if (!accept && valid) begin
                out_cnt <= out_cnt - CNT_W'(1);
            end

            pend_q <= proc_req && !rdy;
            if (viol) begin
                protocol_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        web_q   <= web;
    end

    always_ff @(posedge clk) begin
        if (accept && !web) begin
            mem[idx] <= wdata;
        end
    end

    // Stage 0 of the response pipeline doubles as the RAM read register.
    assign rsp_data = web ? mem[idx] : '0;

    obi_rsp_pipe #(
        .STAGES (LATENCY),
        .DATA_W (OBI_DATA_W)
    ) u_pipe (
        .clk      (clk),
        .clr      (rst),
        .in_vld   (accept),
        .in_data  (rsp_data),
        .out_vld  (valid),
        .out_data (rdata)
    );

endmodule
